// File: rtl/seg_scan_decoder.sv
// Receiver for the scanned 4-digit seven-segment bus; rebuilds 4-symbol frames
// behind a valid/ready handshake. Define SEG_DECODE_STATS_EN to count invalid captures.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYC     = 4,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [3:0]  select_disp,
  input  logic        AE,
  input  logic        BE,
  input  logic        CE,
  input  logic        DE,
  input  logic        EE,
  input  logic        FE,
  input  logic        GE,
  output logic [19:0] frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        overrun,
  output logic        sel_err,
  output logic [7:0]  invalid_cnt
);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_e;

  localparam logic [8:0] SETTLE_TC = 9'(SETTLE_CYC);

  state_e      state_q, state_d;
  logic [3:0]  sel_q;
  logic [6:0]  pat_q;
  logic [3:0]  rsel_q, rsel_d;
  logic [6:0]  rpat_q, rpat_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [19:0] slots_q, slots_d;
  logic [19:0] fdata_q, fdata_d;
  logic        fvalid_q, fvalid_d;
  logic        ovr_q, ovr_d;
  logic        selerr_q, selerr_d;
  logic        one_hot, multi, same, capture;
  logic [4:0]  sym;

  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'd0;
      7'h06: decode = 5'd1;
      7'h5B: decode = 5'd2;
      7'h4F: decode = 5'd3;
      7'h66: decode = 5'd4;
      7'h6D: decode = 5'd5;
      7'h7D: decode = 5'd6;
      7'h07: decode = 5'd7;
      7'h7F: decode = 5'd8;
      7'h6F: decode = 5'd9;
      7'h77: decode = 5'd10;
      7'h7C: decode = 5'd11;
      7'h39: decode = 5'd12;
      7'h5E: decode = 5'd13;
      7'h79: decode = 5'd14;
      7'h71: decode = 5'd15;
      7'h00: decode = 5'd16;
      7'h40: decode = 5'd17;
      default: decode = 5'd31;
    endcase
  endfunction

  // Bus is registered once and normalised to active-high here
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= 4'd0;
      pat_q <= 7'd0;
    end else begin
      sel_q <= select_disp ^ {4{SEL_ACTIVE_LOW}};
      pat_q <= {GE, FE, EE, DE, CE, BE, AE} ^ {7{SEG_ACTIVE_LOW}};
    end
  end

  assign one_hot = (sel_q != 4'd0) && ((sel_q & (sel_q - 4'd1)) == 4'd0);
  assign multi   = (sel_q != 4'd0) && !one_hot;
  assign same    = (sel_q == rsel_q) && (pat_q == rpat_q);
  assign sym     = decode(pat_q);

  always_comb begin
    state_d  = state_q;
    rsel_d   = rsel_q;
    rpat_d   = rpat_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    slots_d  = slots_q;
    fdata_d  = fdata_q;
    fvalid_d = fvalid_q;
    ovr_d    = ovr_q;
    selerr_d = selerr_q;
    capture  = 1'b0;

    if (mask_q == 4'hF) begin
      mask_d = 4'd0;
      if (!fvalid_q || frame_ready) begin
        fdata_d  = slots_q;
        fvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (fvalid_q && frame_ready) begin
      fvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
          rsel_d  = sel_q;
          rpat_d  = pat_q;
        end else if (multi) begin
          selerr_d = 1'b1;
        end
      end
      SETTLE, HOLD: begin
        if (!same) begin
          if (one_hot) begin
            state_d = SETTLE;
            cnt_d   = 8'd1;
            rsel_d  = sel_q;
            rpat_d  = pat_q;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else if (state_q == SETTLE) begin
          cnt_d = cnt_q + 8'd1;
          if ({1'b0, cnt_q} + 9'd1 >= SETTLE_TC) begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // sel_q equals the recorded select whenever a capture fires
    if (capture) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) slots_d[5*i +: 5] = sym;
      end
      mask_d = mask_d | sel_q;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rsel_q   <= 4'd0;
      rpat_q   <= 7'd0;
      cnt_q    <= 8'd0;
      mask_q   <= 4'd0;
      slots_q  <= 20'd0;
      fdata_q  <= 20'd0;
      fvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      selerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rsel_q   <= rsel_d;
      rpat_q   <= rpat_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      slots_q  <= slots_d;
      fdata_q  <= fdata_d;
      fvalid_q <= fvalid_d;
      ovr_q    <= ovr_d;
      selerr_q <= selerr_d;
    end
  end

`ifdef SEG_DECODE_STATS_EN
  logic [7:0] inv_q;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n)
      inv_q <= 8'd0;
    else if (capture && (sym == 5'd31) && (inv_q != 8'hFF))
      inv_q <= inv_q + 8'd1;
  end

  assign invalid_cnt = inv_q;
`else
  assign invalid_cnt = 8'd0;
`endif

  assign frame_data  = fdata_q;
  assign frame_valid = fvalid_q;
  assign overrun     = ovr_q;
  assign sel_err     = selerr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomised and directed bench for seg_scan_decoder, checked against a run-length
// reference model of the scanned display bus.
module tb_seg_scan_decoder;

  localparam int SC = 4;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  select_disp = 4'hF;
  logic        AE = 1'b1, BE = 1'b1, CE = 1'b1, DE = 1'b1, EE = 1'b1, FE = 1'b1, GE = 1'b1;
  logic        frame_ready = 1'b0;
  logic [19:0] frame_data;
  logic        frame_valid;
  logic        overrun;
  logic        sel_err;
  logic [7:0]  invalid_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state (values expected after the most recent edge)
  logic [3:0]  m_psel;
  logic [6:0]  m_ppat;
  bit          m_prev_oh;
  logic [3:0]  m_rsel;
  logic [6:0]  m_rpat;
  int          m_run;
  logic [19:0] m_slots;
  logic [3:0]  m_mask;
  logic        m_fv;
  logic [19:0] m_fd;
  logic        m_ov;
  logic        m_se;
  logic [7:0]  m_inv;

  always #5 mclk = ~mclk;

  seg_scan_decoder #(.SETTLE_CYC(SC), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .mclk(mclk), .rst_n(rst_n), .select_disp(select_disp),
    .AE(AE), .BE(BE), .CE(CE), .DE(DE), .EE(EE), .FE(FE), .GE(GE),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .overrun(overrun), .sel_err(sel_err), .invalid_cnt(invalid_cnt)
  );

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    logic [6:0] tbl [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                             7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00, 7'h40};
    for (int i = 0; i < 18; i++)
      if (tbl[i] == p) return 5'(i);
    return 5'd31;
  endfunction

  task automatic model_reset();
    m_psel = 0; m_ppat = 0; m_prev_oh = 0; m_rsel = 0; m_rpat = 0; m_run = 0;
    m_slots = 0; m_mask = 0; m_fv = 0; m_fd = 0; m_ov = 0; m_se = 0; m_inv = 0;
  endtask

  // One clock edge: the sample registered at the previous edge is judged now.
  task automatic model_edge(input logic ready);
    bit oh;
    logic [4:0] s;
    if (m_mask == 4'hF) begin
      m_mask = 0;
      if (!m_fv || ready) begin m_fd = m_slots; m_fv = 1; end
      else m_ov = 1;
    end else if (m_fv && ready) begin
      m_fv = 0;
    end
    oh = ($countones(m_psel) == 1);
    if (oh) begin
      if (m_prev_oh && m_psel == m_rsel && m_ppat == m_rpat) m_run++;
      else begin m_run = 1; m_rsel = m_psel; m_rpat = m_ppat; end
      if (m_run == SC) begin
        s = ref_decode(m_ppat);
        for (int i = 0; i < 4; i++)
          if (m_psel[i]) begin m_slots[5*i +: 5] = s; m_mask[i] = 1'b1; end
`ifdef SEG_DECODE_STATS_EN
        if (s == 5'd31 && m_inv != 8'hFF) m_inv++;
`endif
      end
    end else if ($countones(m_psel) >= 2 && !m_prev_oh) begin
      m_se = 1;
    end
    m_prev_oh = oh;
  endtask

  // sel and p are given active-high; the pins carry them inverted
  task automatic step(input logic [3:0] sel, input logic [6:0] p, input logic ready);
    select_disp = ~sel;
    {GE, FE, EE, DE, CE, BE, AE} = ~p;
    frame_ready = ready;
    model_edge(ready);
    m_psel = sel;
    m_ppat = p;
    @(posedge mclk);
    #1;
  endtask

  task automatic scan(input int dig, input logic [6:0] p, input int n, input logic ready);
    for (int k = 0; k < n; k++) step(4'(1 << dig), p, ready);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== 31'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0", {frame_valid, frame_data, overrun, sel_err, invalid_cnt});
    end
    select_disp = 4'b1010;
    {GE, FE, EE, DE, CE, BE, AE} = 7'h00;
    frame_ready = 1'b1;
    repeat (3) @(posedge mclk);
    #1;
    n_cmp++;
    if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== 31'd0) begin
      n_err++;
      $display("FAIL reset_held_outputs: got %h required 0", {frame_valid, frame_data, overrun, sel_err, invalid_cnt});
    end
    do_reset();
  endtask

  task automatic test_basic_frame();
    logic [6:0] pats [4] = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
    int pulses = 0;
    do_reset();
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 6; k++) begin
        step(4'(1 << d), pats[d], 1'b1);
        if (frame_valid) pulses++;
        n_cmp++;
        if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== {m_fv, m_fd, m_ov, m_se, m_inv}) begin
          n_err++;
          $display("FAIL basic_cycle d%0d k%0d: got %h required %h", d, k,
                   {frame_valid, frame_data, overrun, sel_err, invalid_cnt}, {m_fv, m_fd, m_ov, m_se, m_inv});
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(4'd0, 7'h00, 1'b1);
      if (frame_valid) pulses++;
    end
    n_cmp++;
    if (pulses !== 1) begin n_err++; $display("FAIL basic_pulses: got %0d required 1", pulses); end
    n_cmp++;
    if (frame_data !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
      n_err++; $display("FAIL basic_data: got %h required %h", frame_data, {5'd3, 5'd2, 5'd1, 5'd0});
    end
  endtask

  task automatic test_glitch();
    do_reset();
    scan(0, 7'h3F, 6, 1'b1);
    for (int k = 0; k < 10; k++) step(4'b0010, ((k / 2) % 2 == 0) ? 7'h7D : 7'h6D, 1'b1);
    n_cmp++;
    if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== {m_fv, m_fd, m_ov, m_se, m_inv}) begin
      n_err++; $display("FAIL glitch_toggle: got %h required %h",
                        {frame_valid, frame_data, overrun, sel_err, invalid_cnt}, {m_fv, m_fd, m_ov, m_se, m_inv});
    end
    scan(1, 7'h7D, 6, 1'b1);
    scan(2, 7'h5B, 6, 1'b1);
    scan(3, 7'h4F, 6, 1'b1);
    step(4'd0, 7'h00, 1'b1);
    n_cmp++;
    if (frame_data !== {5'd3, 5'd2, 5'd6, 5'd0}) begin
      n_err++; $display("FAIL glitch_slot1: got %h required %h", frame_data, {5'd3, 5'd2, 5'd6, 5'd0});
    end
  endtask

  task automatic test_overrun();
    do_reset();
    scan(0, 7'h3F, 6, 1'b0); scan(1, 7'h06, 6, 1'b0);
    scan(2, 7'h5B, 6, 1'b0); scan(3, 7'h4F, 6, 1'b0);
    scan(0, 7'h7F, 6, 1'b0); scan(1, 7'h6F, 6, 1'b0);
    scan(2, 7'h77, 6, 1'b0); scan(3, 7'h71, 6, 1'b0);
    step(4'd0, 7'h00, 1'b0);
    step(4'd0, 7'h00, 1'b0);
    n_cmp++;
    if ({frame_valid, overrun, frame_data} !== {1'b1, 1'b1, 5'd3, 5'd2, 5'd1, 5'd0}) begin
      n_err++; $display("FAIL overrun_hold: got %h required %h", {frame_valid, overrun, frame_data},
                        {1'b1, 1'b1, 5'd3, 5'd2, 5'd1, 5'd0});
    end
    step(4'd0, 7'h00, 1'b1);
    n_cmp++;
    if (frame_valid !== 1'b0) begin n_err++; $display("FAIL overrun_consume: got %b required 0", frame_valid); end
    n_cmp++;
    if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== {m_fv, m_fd, m_ov, m_se, m_inv}) begin
      n_err++; $display("FAIL overrun_model: got %h required %h",
                        {frame_valid, frame_data, overrun, sel_err, invalid_cnt}, {m_fv, m_fd, m_ov, m_se, m_inv});
    end
  endtask

  task automatic test_sel_err();
    do_reset();
    scan(0, 7'h3F, 6, 1'b1);
    n_cmp++;
    if (sel_err !== 1'b0) begin n_err++; $display("FAIL sel_err_pre: got %b required 0", sel_err); end
    for (int k = 0; k < 3; k++) step(4'b0101, 7'h06, 1'b1);
    step(4'd0, 7'h00, 1'b1);
    n_cmp++;
    if (sel_err !== 1'b1) begin n_err++; $display("FAIL sel_err_set: got %b required 1", sel_err); end
    scan(1, 7'h06, 6, 1'b1); scan(2, 7'h5B, 6, 1'b1); scan(3, 7'h4F, 6, 1'b1);
    step(4'd0, 7'h00, 1'b1);
    n_cmp++;
    if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== {m_fv, m_fd, m_ov, m_se, m_inv}) begin
      n_err++; $display("FAIL sel_err_frame: got %h required %h",
                        {frame_valid, frame_data, overrun, sel_err, invalid_cnt}, {m_fv, m_fd, m_ov, m_se, m_inv});
    end
  endtask

  task automatic test_special_symbols();
    logic [6:0] pats [3] = '{7'h49, 7'h00, 7'h40};
    logic [4:0] syms [3] = '{5'd31, 5'd16, 5'd17};
    do_reset();
    for (int f = 0; f < 3; f++) begin
      scan(0, 7'h3F, 6, 1'b1); scan(1, 7'h3F, 6, 1'b1);
      scan(2, pats[f], 6, 1'b1); scan(3, 7'h3F, 6, 1'b1);
      step(4'd0, 7'h00, 1'b1);
      n_cmp++;
      if (frame_data[14:10] !== syms[f]) begin
        n_err++; $display("FAIL special_sym f%0d: got %0d required %0d", f, frame_data[14:10], syms[f]);
      end
    end
    n_cmp++;
`ifdef SEG_DECODE_STATS_EN
    if (invalid_cnt !== 8'd1) begin n_err++; $display("FAIL invalid_cnt: got %0d required 1", invalid_cnt); end
`else
    if (invalid_cnt !== 8'd0) begin n_err++; $display("FAIL invalid_cnt: got %0d required 0", invalid_cnt); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    int seen = 0;
    do_reset();
    scan(0, 7'h3F, 6, 1'b1); scan(1, 7'h06, 6, 1'b1); scan(2, 7'h5B, 6, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== 31'd0) begin
      n_err++; $display("FAIL midreset_outputs: got %h required 0", {frame_valid, frame_data, overrun, sel_err, invalid_cnt});
    end
    @(negedge mclk);
    rst_n = 1'b1;
    scan(3, 7'h4F, 8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(4'd0, 7'h00, 1'b1);
      if (frame_valid) seen++;
    end
    n_cmp++;
    if (seen !== 0 || frame_valid !== 1'b0) begin
      n_err++; $display("FAIL midreset_no_frame: got %0d valid cycles required 0", seen + int'(frame_valid));
    end
  endtask

  task automatic test_random();
    logic [6:0] tbl [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                             7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00, 7'h40};
    logic [3:0] sel;
    logic [6:0] p;
    int dwell, r;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 8) sel = 4'(1 << $urandom_range(0, 3));
      else if (r == 8) sel = 4'd0;
      else sel = 4'($urandom);
      p = ($urandom_range(0, 9) < 8) ? tbl[$urandom_range(0, 17)] : 7'($urandom);
      dwell = $urandom_range(1, 8);
      for (int k = 0; k < dwell; k++) begin
        step(sel, p, 1'($urandom));
        n_cmp++;
        if ({frame_valid, frame_data, overrun, sel_err, invalid_cnt} !== {m_fv, m_fd, m_ov, m_se, m_inv}) begin
          n_err++;
          $display("FAIL random it%0d k%0d: got %h required %h", it, k,
                   {frame_valid, frame_data, overrun, sel_err, invalid_cnt}, {m_fv, m_fd, m_ov, m_se, m_inv});
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_glitch();
    test_overrun();
    test_sel_err();
    test_special_symbols();
    test_reset_mid_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
